// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair: polynomial defaults,
// checker state encoding and the feedback-parity helper.
package prbs_pkg;

  localparam int unsigned PRBS_WIDTH    = 8;
  localparam int unsigned PRBS_FB_MAX_W = 32;
  localparam logic [PRBS_WIDTH-1:0] PRBS_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  // Next-bit prediction: parity of the tapped state bits (zero-extended operands).
  function automatic logic prbs_fb(input logic [PRBS_FB_MAX_W-1:0] s,
                                   input logic [PRBS_FB_MAX_W-1:0] taps);
    return ^(s & taps);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear with a simultaneous
// increment lands on one so that event is not lost.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: seeds a local LFSR from the stream,
// verifies predictions before locking, then counts errors against a free-running copy.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned            WIDTH      = PRBS_WIDTH,
  parameter logic [WIDTH-1:0]       TAPS       = WIDTH'(PRBS_TAPS),
  parameter int unsigned            LOCK_COUNT = 16,
  parameter int unsigned            LOSS_COUNT = 4,
  parameter int unsigned            ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count,
  output logic             err_pulse,
  output logic             lock_lost
);

  localparam int unsigned SEED_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_COUNT + 1);

  prbs_state_e        state, state_n;
  logic [WIDTH-1:0]   s, s_n;
  logic [SEED_W-1:0]  seed_cnt, seed_n;
  logic [MATCH_W-1:0] match_cnt, match_n;
  logic [MISS_W-1:0]  miss_cnt, miss_n;
  logic               fb;
  logic               consume;
  logic               err_hit;
  logic               lost_hit;

  assign consume = ena && bit_valid;
  assign fb      = prbs_fb(PRBS_FB_MAX_W'(s), PRBS_FB_MAX_W'(TAPS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SEED;
      s         <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_n;
      s         <= s_n;
      seed_cnt  <= seed_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      locked    <= (state_n == ST_LOCKED);
      err_pulse <= err_hit;
      lock_lost <= lost_hit;
    end
  end

  always_comb begin
    state_n  = state;
    s_n      = s;
    seed_n   = seed_cnt;
    match_n  = match_cnt;
    miss_n   = miss_cnt;
    err_hit  = 1'b0;
    lost_hit = 1'b0;
    if (consume) begin
      case (state)
        ST_SEED: begin
          s_n = {s[WIDTH-2:0], bit_in};
          if (seed_cnt == SEED_W'(WIDTH - 1)) begin
            state_n = ST_VERIFY;
            seed_n  = '0;
            match_n = '0;
          end else begin
            seed_n = seed_cnt + SEED_W'(1);
          end
        end
        ST_VERIFY: begin
          s_n = {s[WIDTH-2:0], bit_in};
          if (bit_in == fb) begin
            if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
              state_n = ST_LOCKED;
              match_n = '0;
              miss_n  = '0;
            end else begin
              match_n = match_cnt + MATCH_W'(1);
            end
          end else begin
            match_n = '0;
          end
          // An all-zero register predicts zeros forever; force a reseed instead.
          if (s_n == '0) begin
            state_n = ST_SEED;
            seed_n  = '0;
            match_n = '0;
          end
        end
        ST_LOCKED: begin
          s_n = {s[WIDTH-2:0], fb};
          if (bit_in != fb) begin
            err_hit = 1'b1;
            if (miss_cnt == MISS_W'(LOSS_COUNT - 1)) begin
              state_n  = ST_SEED;
              seed_n   = '0;
              miss_n   = '0;
              lost_hit = 1'b1;
            end else begin
              miss_n = miss_cnt + MISS_W'(1);
            end
          end else begin
            miss_n = '0;
          end
        end
        default: state_n = ST_SEED;
      endcase
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_hit),
    .clear (ena && clear_err),
    .count (err_count)
  );

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: two instances (8-bit and 2-bit error
// counters) share stimulus; a queue-based reference model predicts every cycle.
module tb_prbs_checker;

  localparam int unsigned      WIDTH      = 8;
  localparam logic [WIDTH-1:0] TAPS       = 8'hB8;
  localparam int               LOCK_COUNT = 16;
  localparam int               LOSS_COUNT = 4;

  typedef struct {
    bit locked;
    bit pulse;
    bit lost;
    int e8;
    int e2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, ena, bit_in, bit_valid, clear_err;
  logic       locked_a, pulse_a, lost_a, locked_b, pulse_b, lost_b;
  logic [7:0] err_a;
  logic [1:0] err_b;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  // Reference model state
  int   m_mode;  // 0 seed, 1 verify, 2 locked
  int   m_cnt, m_miss, m_e8, m_e2;
  bit   m_win[$];
  logic [WIDTH-1:0] g;

  always #5 clk = ~clk;

  prbs_checker #(.WIDTH(WIDTH), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT),
                 .LOSS_COUNT(LOSS_COUNT), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_err(clear_err), .locked(locked_a), .err_count(err_a),
    .err_pulse(pulse_a), .lock_lost(lost_a)
  );

  prbs_checker #(.WIDTH(WIDTH), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT),
                 .LOSS_COUNT(LOSS_COUNT), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_err(clear_err), .locked(locked_b), .err_count(err_b),
    .err_pulse(pulse_b), .lock_lost(lost_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_miss = 0; m_e8 = 0; m_e2 = 0;
    m_win.delete();
    repeat (WIDTH) m_win.push_back(1'b0);
  endtask

  // Behavioural model: window holds the last WIDTH register bits, newest at the back.
  task automatic model_step(input bit r, input bit e, input bit v, input bit b,
                            input bit c, output exp_t x);
    bit pred, allz;
    logic [WIDTH-1:0] t;
    x.pulse = 1'b0;
    x.lost  = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      if (e && c) begin m_e8 = 0; m_e2 = 0; end
      if (e && v) begin
        pred = 1'b0;
        t = TAPS;
        for (int i = 0; i < WIDTH; i++) begin
          if (t[0]) pred ^= m_win[WIDTH-1-i];
          t = t >> 1;
        end
        m_win.push_back((m_mode == 2) ? pred : b);
        void'(m_win.pop_front());
        case (m_mode)
          0: begin
            m_cnt++;
            if (m_cnt == WIDTH) begin m_mode = 1; m_cnt = 0; end
          end
          1: begin
            m_cnt = (b == pred) ? m_cnt + 1 : 0;
            allz = 1'b1;
            foreach (m_win[i]) if (m_win[i]) allz = 1'b0;
            if (allz) begin m_mode = 0; m_cnt = 0; end
            else if (m_cnt == LOCK_COUNT) begin m_mode = 2; m_cnt = 0; m_miss = 0; end
          end
          default: begin
            if (b != pred) begin
              if (m_e8 < 255) m_e8++;
              if (m_e2 < 3) m_e2++;
              x.pulse = 1'b1;
              m_miss++;
              if (m_miss == LOSS_COUNT) begin m_mode = 0; m_cnt = 0; m_miss = 0; x.lost = 1'b1; end
            end else begin
              m_miss = 0;
            end
          end
        endcase
      end
    end
    x.locked = (m_mode == 2);
    x.e8 = m_e8;
    x.e2 = m_e2;
  endtask

  task automatic drive(input bit r, input bit e, input bit v, input bit b, input bit c);
    exp_t x;
    @(negedge clk);
    rst = r; ena = e; bit_valid = v; bit_in = b; clear_err = c;
    model_step(r, e, v, b, c, x);
    q.push_back(x);
  endtask

  task automatic gen_bit(output bit b);
    b = ^(g & TAPS);
    g = {g[WIDTH-2:0], b};
  endtask

  task automatic send(input bit flip, input bit c);
    bit b;
    gen_bit(b);
    drive(1'b0, 1'b1, 1'b1, b ^ flip, c);
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b0, 1'($urandom), 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per consuming edge, compared just after that edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("locked_a", 32'(locked_a), 32'(x.locked));
        check("locked_b", 32'(locked_b), 32'(x.locked));
        check("err_pulse_a", 32'(pulse_a), 32'(x.pulse));
        check("err_pulse_b", 32'(pulse_b), 32'(x.pulse));
        check("lock_lost_a", 32'(lost_a), 32'(x.lost));
        check("lock_lost_b", 32'(lost_b), 32'(x.lost));
        check("err_count_a", 32'(err_a), 32'(x.e8));
        check("err_count_b", 32'(err_b), 32'(x.e2));
      end
    end
  end

  initial begin
    int  r;
    bit  e, v, b, c;
    int  burst;
    rst = 1'b1; ena = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear_err = 1'b0;
    model_reset();
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean stream from seed 01: lock on the 24th valid bit
    g = 8'h01;
    for (int i = 0; i < 24; i++) begin
      send(1'b0, 1'b0);
      if (i == 22) begin settle(); check("pre_lock", 32'(locked_a), 32'd0); end
    end
    settle();
    check("lock_24", 32'(locked_a), 32'd1);
    check("err_zero_at_lock", 32'(err_a), 32'd0);

    // Three isolated errors
    repeat (10) send(1'b0, 1'b0);
    repeat (3) begin
      send(1'b1, 1'b0);
      repeat (9) send(1'b0, 1'b0);
    end
    settle();
    check("three_errs", 32'(err_a), 32'd3);

    // Four consecutive errors drop lock; clean stream relocks
    repeat (4) send(1'b1, 1'b0);
    settle();
    check("burst_unlock", 32'(locked_a), 32'd0);
    check("burst_errs", 32'(err_a), 32'd7);
    repeat (24) send(1'b0, 1'b0);
    settle();
    check("relock", 32'(locked_a), 32'd1);

    // All-zero stream never locks
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (100) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    check("zeros_no_lock", 32'(locked_a), 32'd0);
    check("zeros_no_err", 32'(err_a), 32'd0);

    // Saturation on the 2-bit counter, then clear with a simultaneous error
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    g = 8'h01;
    repeat (28) send(1'b0, 1'b0);
    repeat (6) begin
      send(1'b1, 1'b0);
      repeat (5) send(1'b0, 1'b0);
    end
    settle();
    check("sat_b", 32'(err_b), 32'd3);
    check("unsat_a", 32'(err_a), 32'd6);
    send(1'b1, 1'b1);
    settle();
    check("clear_with_err_b", 32'(err_b), 32'd1);

    // Valid gaps and an ena-low window during VERIFY, then reset while locked
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    g = 8'h01;
    for (int n = 0; n < 70; n++) begin
      if (n >= 20 && n < 25) drive(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
      else if (n % 2 == 1) send(1'b0, 1'b0);
      else idle();
    end
    settle();
    check("gapped_lock", 32'(locked_a), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    check("rst_locked", 32'(locked_a), 32'd0);

    // Randomised traffic: gaps, enable drops, isolated and burst errors, clears, resets
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(999, 0);
      v = ($urandom_range(3, 0) != 0);
      e = ($urandom_range(15, 0) != 0);
      c = ($urandom_range(99, 0) == 0);
      if (burst == 0 && $urandom_range(149, 0) == 0) burst = $urandom_range(6, 3);
      if (r < 2) begin
        drive(1'b1, e, v, 1'($urandom), c);
      end else if (e && v) begin
        gen_bit(b);
        if (burst > 0) begin b = ~b; burst--; end
        else if ($urandom_range(39, 0) == 0) b = ~b;
        drive(1'b0, e, v, b, c);
      end else begin
        drive(1'b0, e, v, 1'($urandom), c);
      end
    end

    repeat (3) idle();
    settle();
    check("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
